// File: rtl/inst_fetch_if.sv
// Fetch-side port onto the shared instruction/data SRAM.
// The fetch stage is the master; the SRAM arbiter/memory model is the slave.
interface inst_fetch_if #(
  parameter int PC_WIDTH   = 16,
  parameter int INST_WIDTH = 16
);
  logic                  mem_req;
  logic [PC_WIDTH-1:0]   mem_addr;
  logic                  mem_busy;
  logic                  mem_ready;
  logic [INST_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_busy,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_busy,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// presents if_pc/if_inst/if_valid to the if_id register, with one branch delay slot.
module inst_fetch #(
  parameter int                    PC_WIDTH   = 16,
  parameter int                    INST_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 16'h0000,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 16'h0800
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_pc,
  input  logic                  branch_flag,
  input  logic [PC_WIDTH-1:0]   branch_target,
  inst_fetch_if.master          mem,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  if_valid,
  output logic                  fetch_stall_req
);

  localparam logic                STALL_YES = 1'b1;
  localparam logic [PC_WIDTH-1:0] PC_ONE    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
  logic                  if_valid_q, if_valid_d;
  logic                  done;

  assign mem.mem_req     = (state_q == FETCH) && !mem.mem_busy;
  assign mem.mem_addr    = pc_q;
  assign done            = mem.mem_req && mem.mem_ready;
  assign fetch_stall_req = (state_q == FETCH) && !done;

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;

    // A taken branch drops whatever was in flight but leaves if_pc alone (delay slot).
    if (branch_flag && (stall_pc != STALL_YES)) begin
      pc_d        = branch_target;
      state_d     = FETCH;
      skid_pc_d   = '0;
      skid_inst_d = '0;
      if_valid_d  = 1'b0;
      if_inst_d   = NOP_INST;
    end else if (stall_pc == STALL_YES) begin
      if ((state_q == FETCH) && done) begin
        skid_pc_d   = pc_q;
        skid_inst_d = mem.mem_rdata;
        pc_d        = pc_q + PC_ONE;
        state_d     = HOLD;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (done) begin
            if_pc_d    = pc_q;
            if_inst_d  = mem.mem_rdata;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_ONE;
          end else begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
          end
        end
        HOLD: begin
          if_pc_d     = skid_pc_q;
          if_inst_d   = skid_inst_q;
          if_valid_d  = 1'b1;
          skid_pc_d   = '0;
          skid_inst_d = '0;
          state_d     = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= NOP_INST;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: SRAM returns 0x0100+addr, expected values are hand-computed.
module tb_inst_fetch;
  logic        clk;
  logic        rst;
  logic        stall_pc;
  logic        branch_flag;
  logic [15:0] branch_target;
  logic [15:0] if_pc;
  logic [15:0] if_inst;
  logic        if_valid;
  logic        fetch_stall_req;
  int          total;
  int          bad;

  inst_fetch_if #(.PC_WIDTH(16), .INST_WIDTH(16)) bus ();

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_pc        (stall_pc),
    .branch_flag     (branch_flag),
    .branch_target   (branch_target),
    .mem             (bus.master),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_valid        (if_valid),
    .fetch_stall_req (fetch_stall_req)
  );

  assign bus.mem_rdata = 16'h0100 + bus.mem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_if(input string tag, input logic [15:0] pc, input logic [15:0] inst,
                          input logic valid);
    check({tag, ".if_pc"}, 32'(if_pc), 32'(pc));
    check({tag, ".if_inst"}, 32'(if_inst), 32'(inst));
    check({tag, ".if_valid"}, 32'(if_valid), 32'(valid));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    stall_pc = 1'b0;
    branch_flag = 1'b0;
    branch_target = 16'h0000;
    bus.mem_busy = 1'b0;
    bus.mem_ready = 1'b0;

    // reset state
    repeat (2) cyc();
    check_if("reset", 16'h0000, 16'h0800, 1'b0);
    check("reset.mem_req", 32'(bus.mem_req), 32'd0);
    check("reset.stall_req", 32'(fetch_stall_req), 32'd0);

    rst = 1'b1;
    cyc();
    check("release.mem_req", 32'(bus.mem_req), 32'd1);
    check("release.mem_addr", 32'(bus.mem_addr), 32'h0000);

    // back-to-back fetches
    bus.mem_ready = 1'b1;
    cyc();
    check_if("seq0", 16'h0000, 16'h0100, 1'b1);
    cyc();
    check_if("seq1", 16'h0001, 16'h0101, 1'b1);
    cyc();
    check_if("seq2", 16'h0002, 16'h0102, 1'b1);

    // two wait cycles at address 3
    bus.mem_ready = 1'b0;
    #1;
    check("wait.stall_req", 32'(fetch_stall_req), 32'd1);
    check("wait.addr0", 32'(bus.mem_addr), 32'h0003);
    cyc();
    check("wait1.if_valid", 32'(if_valid), 32'd0);
    check("wait1.if_inst", 32'(if_inst), 32'h0800);
    check("wait1.addr", 32'(bus.mem_addr), 32'h0003);
    cyc();
    check("wait2.if_valid", 32'(if_valid), 32'd0);
    check("wait2.addr", 32'(bus.mem_addr), 32'h0003);
    bus.mem_ready = 1'b1;
    cyc();
    check_if("after_wait", 16'h0003, 16'h0103, 1'b1);
    cyc();
    check_if("seq4", 16'h0004, 16'h0104, 1'b1);

    // stall while fetch at 5 completes -> skid, HOLD
    stall_pc = 1'b1;
    cyc();
    check_if("hold", 16'h0004, 16'h0104, 1'b1);
    check("hold.mem_req", 32'(bus.mem_req), 32'd0);
    check("hold.stall_req", 32'(fetch_stall_req), 32'd0);
    cyc();
    check_if("hold2", 16'h0004, 16'h0104, 1'b1);
    stall_pc = 1'b0;
    cyc();
    check_if("release_skid", 16'h0005, 16'h0105, 1'b1);
    check("release_skid.addr", 32'(bus.mem_addr), 32'h0006);
    cyc();
    check_if("seq6", 16'h0006, 16'h0106, 1'b1);
    cyc();
    check_if("seq7", 16'h0007, 16'h0107, 1'b1);

    // branch while fetching 8
    branch_flag = 1'b1;
    branch_target = 16'h0040;
    #1;
    check("br.addr_before", 32'(bus.mem_addr), 32'h0008);
    cyc();
    check("br.if_valid", 32'(if_valid), 32'd0);
    check("br.if_inst", 32'(if_inst), 32'h0800);
    check("br.addr", 32'(bus.mem_addr), 32'h0040);
    branch_flag = 1'b0;
    cyc();
    check_if("br_target", 16'h0040, 16'h0140, 1'b1);

    // branch ignored while stalled
    stall_pc = 1'b1;
    branch_flag = 1'b1;
    branch_target = 16'h0080;
    cyc();
    check_if("br_stall", 16'h0040, 16'h0140, 1'b1);
    check("br_stall.mem_req", 32'(bus.mem_req), 32'd0);
    check("br_stall.addr", 32'(bus.mem_addr), 32'h0042);
    stall_pc = 1'b0;
    branch_flag = 1'b0;
    cyc();
    check_if("br_stall_rel", 16'h0041, 16'h0141, 1'b1);
    check("br_stall_rel.addr", 32'(bus.mem_addr), 32'h0042);

    // structural hazard: ready without req is ignored
    bus.mem_busy = 1'b1;
    #1;
    check("busy.mem_req", 32'(bus.mem_req), 32'd0);
    check("busy.stall_req", 32'(fetch_stall_req), 32'd1);
    cyc();
    check("busy.if_valid", 32'(if_valid), 32'd0);
    check("busy.addr", 32'(bus.mem_addr), 32'h0042);

    // PC wrap from 0xFFFF
    branch_flag = 1'b1;
    branch_target = 16'hFFFF;
    cyc();
    check("wrap.addr_ffff", 32'(bus.mem_addr), 32'hFFFF);
    branch_flag = 1'b0;
    bus.mem_busy = 1'b0;
    #1;
    check("wrap.mem_req", 32'(bus.mem_req), 32'd1);
    cyc();
    check_if("wrap", 16'hFFFF, 16'h00FF, 1'b1);
    check("wrap.addr", 32'(bus.mem_addr), 32'h0000);

    // asynchronous reset mid-wait
    bus.mem_ready = 1'b0;
    cyc();
    check("midwait.if_pc", 32'(if_pc), 32'hFFFF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_if("async_rst", 16'h0000, 16'h0800, 1'b0);
    check("async_rst.mem_req", 32'(bus.mem_req), 32'd0);
    check("async_rst.stall_req", 32'(fetch_stall_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
